// File: rtl/port_bus_pkg.sv
// ---------------------------------------------------------------------------
// port_bus_pkg
// Shared definitions for the port serial bus. Both the bus master and the
// remote expander use these.
//   - Slot layout: every port takes SLOTS_PER_PORT slots per frame. The offsets
//     of the DIR, READ and WRITE slots are measured from 3*p.
//   - slot_last(): index of the final slot of a frame. Slot 0 is the sync slot.
//   - bus_state_e: the frame FSM encoding.
// ---------------------------------------------------------------------------
package port_bus_pkg;

  localparam int SLOTS_PER_PORT = 3;
  localparam int SLOT_DIR       = 1;
  localparam int SLOT_READ      = 2;
  localparam int SLOT_WRITE     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } bus_state_e;

  // A frame is slot 0 (sync), then 3 slots per port, then one trailing LAST slot.
  function automatic int slot_last(input int nports);
    return SLOTS_PER_PORT * nports + 1;
  endfunction

endpackage

// File: rtl/port_io_expander_if.sv
// ---------------------------------------------------------------------------
// port_io_expander_if
// Bus-side signals of the port serial bus.
//   port_rst : frame sync. It is high for one cycle, and that cycle is slot 0.
//   data_in  : bus data sampled from the pad.
//   data_out : data the expander drives in its READ slots.
//   data_oe  : pad output enable for data_out.
// Modports:
//   master : the bus master. It drives port_rst and data_in.
//   slave  : the expander. It drives data_out and data_oe.
// ---------------------------------------------------------------------------
interface port_io_expander_if;
  logic       port_rst;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output port_rst,
    output data_in,
    input  data_out,
    input  data_oe
  );

  modport slave (
    input  port_rst,
    input  data_in,
    output data_out,
    output data_oe
  );
endinterface

// File: rtl/port_pin_sync.sv
// ---------------------------------------------------------------------------
// port_pin_sync
// A WIDTH-bit two-flop synchroniser for asynchronous physical pin inputs.
//   clk     : destination clock
//   rst     : synchronous, active-high reset. It clears both stages.
//   i_async : asynchronous input bits
//   o_sync  : synchronised bits. They lag i_async by 2 cycles.
// ---------------------------------------------------------------------------
module port_pin_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/port_io_expander.sv
// ---------------------------------------------------------------------------
// port_io_expander
// Remote-side slave of the port serial bus. It follows the master's slot
// sequence, and each frame begins with port_rst.
// For each port it does three things:
//   - latches a direction byte in the DIR slot,
//   - commits the direction byte and the output byte together in the WRITE slot,
//   - returns the synchronised pin inputs on the bus in the READ slot.
// The pad tristate (data = data_oe ? data_out : 'z) is kept outside this block.
// Ports:
//   clk, rst     : bus clock; synchronous, active-high reset
//   bus          : slave modport (port_rst, data_in in; data_out, data_oe out)
//   i_pin_in     : asynchronous pin inputs, port p = [8p+7:8p]
//   o_pin_out    : pin output values
//   o_pin_oe     : pin output enables (1 = drive)
//   o_frame_done : one-cycle pulse during the LAST slot
//   o_frame_err  : one-cycle pulse in the cycle after a premature sync
//   o_link_lost  : level; the watchdog has expired without a sync
// ---------------------------------------------------------------------------
module port_io_expander
  import port_bus_pkg::*;
#(
  parameter int NPORTS  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  port_io_expander_if.slave     bus,
  input  logic [8*NPORTS-1:0]   i_pin_in,
  output logic [8*NPORTS-1:0]   o_pin_out,
  output logic [8*NPORTS-1:0]   o_pin_oe,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic                  o_link_lost
);

  localparam int                SLOT_W    = $clog2(SLOTS_PER_PORT * NPORTS + 2);
  localparam logic [SLOT_W-1:0] LAST_S    = SLOT_W'(slot_last(NPORTS));
  localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] TIMEOUT_W = WDOG_W'(TIMEOUT);

  // r_slot is the slot number of the current cycle, except in a cycle where
  // port_rst is high. Such a cycle is slot 0, whatever r_slot says.
  bus_state_e        r_state;
  bus_state_e        w_state_next;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_next;
  logic [SLOT_W-1:0] w_slot_inc;

  logic              w_active;
  logic              w_premature;
  logic              w_done_next;
  logic              w_expire;
  logic [NPORTS-1:0] w_read_next;
  logic              w_read_any;
  logic [7:0]        w_read_data;
  logic [8*NPORTS-1:0] w_pin_sync;

  logic [WDOG_W-1:0] r_wdog;
  logic              r_link_lost;
  logic              r_frame_done;
  logic              r_frame_err;
  logic              r_data_oe;
  logic [7:0]        r_data_out;

  assign w_slot_inc = r_slot + 1'b1;

  port_pin_sync #(.WIDTH(8 * NPORTS)) u_pin_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_pin_in),
    .o_sync  (w_pin_sync)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_next;
      r_slot  <= w_slot_next;
    end
  end

  // ---------------- FSM: next state ----------------
  // A sync always starts a new frame. The cycle after the sync is slot 1.
  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    if (bus.port_rst) begin
      w_state_next = FRAME;
      w_slot_next  = SLOT_W'(1);
    end else if (r_state == FRAME) begin
      if (r_slot == LAST_S) begin
        w_state_next = IDLE;
        w_slot_next  = '0;
      end else begin
        w_slot_next = w_slot_inc;
      end
    end
  end

  // ---------------- FSM: outputs / slot decode ----------------
  // w_active blocks every slot action in a sync cycle. Because of this, a
  // premature sync cancels the DIR, WRITE or READ action of its cycle, as
  // well as the data_oe load for the next slot.
  always_comb begin
    w_active    = (r_state == FRAME) && !bus.port_rst;
    w_premature = bus.port_rst && (r_state == FRAME) && (r_slot != LAST_S);
    w_done_next = w_active && (w_slot_inc == LAST_S);
    w_expire    = !bus.port_rst && (r_wdog == TIMEOUT_W - 1'b1);
  end

  // ---------------- per-port shadow / commit registers ----------------
  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    localparam logic [SLOT_W-1:0] DIR_S   = SLOT_W'(SLOTS_PER_PORT * gi + SLOT_DIR);
    localparam logic [SLOT_W-1:0] READ_S  = SLOT_W'(SLOTS_PER_PORT * gi + SLOT_READ);
    localparam logic [SLOT_W-1:0] WRITE_S = SLOT_W'(SLOTS_PER_PORT * gi + SLOT_WRITE);

    logic [7:0] r_dir_shadow;
    logic [7:0] r_dir;
    logic [7:0] r_out;
    logic       w_dir_hit;
    logic       w_write_hit;

    assign w_dir_hit       = w_active && (r_slot == DIR_S);
    assign w_write_hit     = w_active && (r_slot == WRITE_S);
    assign w_read_next[gi] = w_active && (w_slot_inc == READ_S);

    // The direction and output bytes commit on the same edge. Because of
    // this, a port that changes both never shows a mixed old/new state.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dir_shadow <= '0;
        r_dir        <= '0;
        r_out        <= '0;
      end else begin
        if (w_premature) begin
          r_dir_shadow <= '0;
        end else if (w_dir_hit) begin
          r_dir_shadow <= bus.data_in;
        end

        if (w_write_hit) begin
          r_out <= bus.data_in;
        end

        // On link loss, every pin falls back to an input. The output values are kept.
        if (w_expire) begin
          r_dir <= '0;
        end else if (w_write_hit) begin
          r_dir <= r_dir_shadow;
        end
      end
    end

    assign o_pin_out[8*gi +: 8] = r_out;
    assign o_pin_oe[8*gi +: 8]  = r_dir;
  end

  // ---------------- bus read path ----------------
  // data_oe and data_out are loaded on the edge that enters a READ slot.
  // Because of this, they are valid for exactly that slot.
  always_comb begin
    w_read_any  = 1'b0;
    w_read_data = r_data_out;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_read_next[p]) begin
        w_read_any  = 1'b1;
        w_read_data = w_pin_sync[8*p +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_oe    <= 1'b0;
      r_data_out   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_oe    <= w_read_any;
      r_data_out   <= w_read_data;
      r_frame_done <= w_done_next;
      r_frame_err  <= w_premature;
    end
  end

  // ---------------- watchdog ----------------
  // The watchdog counts cycles since the last sync and saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog      <= '0;
      r_link_lost <= 1'b0;
    end else if (bus.port_rst) begin
      r_wdog      <= '0;
      r_link_lost <= 1'b0;
    end else begin
      if (r_wdog != TIMEOUT_W) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_expire) begin
        r_link_lost <= 1'b1;
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.data_oe   = r_data_oe;
  assign o_frame_done  = r_frame_done;
  assign o_frame_err   = r_frame_err;
  assign o_link_lost   = r_link_lost;

endmodule

// File: tb/tb_port_io_expander.sv
// ---------------------------------------------------------------------------
// tb_port_io_expander
// Self-checking bench for port_io_expander with NPORTS=3 and TIMEOUT=255.
// Each cycle the bench first checks the outputs of the current slot, at #1
// after the edge. Then it drives the inputs for that slot.
// A READ slot pushes the bench's own pin byte onto a scoreboard queue. In each
// cycle, data_oe must equal "queue holds an entry". On a bus read, data_out is
// compared with the popped entry.
// ---------------------------------------------------------------------------
module tb_port_io_expander;
  import port_bus_pkg::*;

  localparam int NPORTS  = 3;
  localparam int TIMEOUT = 255;
  localparam int LAST    = slot_last(NPORTS);

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pin_val;
  logic [23:0] pin_out;
  logic [23:0] pin_oe;
  logic        frame_done;
  logic        frame_err;
  logic        link_lost;

  always #5 clk = ~clk;

  port_io_expander_if bus_if ();

  port_io_expander #(.NPORTS(NPORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .i_pin_in     (pin_val),
    .o_pin_out    (pin_out),
    .o_pin_oe     (pin_oe),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_link_lost  (link_lost)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic        prst;
    logic [7:0]  din;
    logic [23:0] exp_oe;
    logic [23:0] exp_out;
    logic        exp_done;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bus();
    logic       exp_oe;
    logic [7:0] exp_byte;
    exp_oe = (sb_q.size() > 0);
    chk("data_oe", {31'd0, bus_if.data_oe}, {31'd0, exp_oe});
    if (exp_oe) begin
      exp_byte = sb_q.pop_front();
      chk("data_out", {24'd0, bus_if.data_out}, {24'd0, exp_byte});
      $display("bus read: data_out=0x%02h expected=0x%02h t=%0t", bus_if.data_out, exp_byte, $time);
    end
  endtask

  // Checks the current cycle, drives its inputs, and advances to the next cycle.
  task automatic tick(input logic prst, input logic [7:0] din, input bit rd, input int rd_port,
                      input logic exp_done, input logic exp_err);
    if (rd) sb_q.push_back(pin_val[8*rd_port +: 8]);
    check_bus();
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
    chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    bus_if.port_rst = prst;
    bus_if.data_in  = din;
    @(posedge clk);
    #1;
  endtask

  // Runs the non-sync slots of a frame. dirs[p] and outs[p] are written to port p.
  task automatic run_slots(input int s_from, input int s_to,
                           input logic [2:0][7:0] dirs, input logic [2:0][7:0] outs);
    logic [7:0] din;
    bit         rd;
    int         p;
    for (int s = s_from; s <= s_to; s++) begin
      din = 8'h00;
      rd  = 1'b0;
      p   = 0;
      if (s % 3 == 1 && s <= 3*NPORTS-2) din = dirs[(s-1)/3];
      if (s % 3 == 0 && s >= 3 && s <= 3*NPORTS) din = outs[(s-3)/3];
      if (s % 3 == 2 && s <= 3*NPORTS-1) begin
        rd = 1'b1;
        p  = (s-2)/3;
      end
      tick(1'b0, din, rd, p, (s == LAST), 1'b0);
    end
  endtask

  logic [2:0][7:0] dirs_a;
  logic [2:0][7:0] outs_a;

  initial begin
    // ---- 1. reset with random inputs ----
    rst             = 1'b1;
    bus_if.port_rst = 1'($urandom_range(0, 1));
    bus_if.data_in  = 8'($urandom);
    pin_val         = 24'($urandom);
    @(posedge clk);
    #1;
    bus_if.port_rst = 1'($urandom_range(0, 1));
    bus_if.data_in  = 8'($urandom);
    pin_val         = 24'($urandom);
    @(posedge clk);
    #1;
    chk("rst_pin_oe", {8'd0, pin_oe}, 32'd0);
    chk("rst_pin_out", {8'd0, pin_out}, 32'd0);
    chk("rst_data_oe", {31'd0, bus_if.data_oe}, 32'd0);
    chk("rst_data_out", {24'd0, bus_if.data_out}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_link_lost", {31'd0, link_lost}, 32'd0);

    rst     = 1'b0;
    pin_val = 24'h77_3C_11;
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);

    // ---- 2/3. frame from IDLE: program all ports, read back the pins ----
    tbl[0]  = '{1'b1, 8'h00, 24'h000000, 24'h000000, 1'b0};
    tbl[1]  = '{1'b0, 8'h0F, 24'h000000, 24'h000000, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 24'h000000, 24'h000000, 1'b0};
    tbl[3]  = '{1'b0, 8'hA5, 24'h000000, 24'h000000, 1'b0};
    tbl[4]  = '{1'b0, 8'hF0, 24'h00000F, 24'h0000A5, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 24'h00000F, 24'h0000A5, 1'b0};
    tbl[6]  = '{1'b0, 8'h5A, 24'h00000F, 24'h0000A5, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 24'h00F00F, 24'h005AA5, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 24'h00F00F, 24'h005AA5, 1'b0};
    tbl[9]  = '{1'b0, 8'h33, 24'h00F00F, 24'h005AA5, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 24'h00F00F, 24'h335AA5, 1'b1};
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tbl%0d_pin_oe", i), {8'd0, pin_oe}, {8'd0, tbl[i].exp_oe});
      chk($sformatf("tbl%0d_pin_out", i), {8'd0, pin_out}, {8'd0, tbl[i].exp_out});
      tick(tbl[i].prst, tbl[i].din, (i % 3 == 2), (i - 2) / 3, tbl[i].exp_done, 1'b0);
    end
    chk("idle_pin_oe", {8'd0, pin_oe}, 32'h00F00F);
    chk("idle_pin_out", {8'd0, pin_out}, 32'h335AA5);

    // ---- 4. premature sync in slot 4 ----
    tick(1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 8'hC3, 1'b0, 0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    tick(1'b0, 8'h96, 1'b0, 0, 1'b0, 1'b0);
    chk("pre_pin_oe", {8'd0, pin_oe}, 32'h00F0C3);
    chk("pre_pin_out", {8'd0, pin_out}, 32'h335A96);
    tick(1'b1, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
    // Slot 1 of the restarted frame: an error pulse, and no READ of port 1.
    chk("err_pin_oe", {8'd0, pin_oe}, 32'h00F0C3);
    chk("err_pin_out", {8'd0, pin_out}, 32'h335A96);
    tick(1'b0, 8'hC3, 1'b0, 0, 1'b0, 1'b1);
    dirs_a = {8'h00, 8'hF0, 8'hC3};
    outs_a = {8'h33, 8'h5A, 8'h96};
    run_slots(2, LAST, dirs_a, outs_a);
    chk("post_err_pin_oe", {8'd0, pin_oe}, 32'h00F0C3);
    chk("post_err_pin_out", {8'd0, pin_out}, 32'h335A96);

    // ---- 5. watchdog: the last sync is at cycle T; link_lost rises at T+256 ----
    tick(1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    run_slots(1, LAST, dirs_a, outs_a);
    for (int i = 0; i < 244; i++) tick(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    chk("wdog_not_yet", {31'd0, link_lost}, 32'd0);
    chk("wdog_pin_oe_before", {8'd0, pin_oe}, 32'h00F0C3);
    tick(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    chk("wdog_link_lost", {31'd0, link_lost}, 32'd1);
    chk("wdog_pin_oe", {8'd0, pin_oe}, 32'd0);
    chk("wdog_pin_out", {8'd0, pin_out}, 32'h335A96);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    chk("wdog_held", {31'd0, link_lost}, 32'd1);
    tick(1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    chk("resync_link_lost", {31'd0, link_lost}, 32'd0);
    chk("resync_pin_oe", {8'd0, pin_oe}, 32'd0);
    dirs_a = {8'h81, 8'h42, 8'h24};
    run_slots(1, LAST, dirs_a, outs_a);
    chk("recommit_pin_oe", {8'd0, pin_oe}, 32'h814224);

    // ---- 6. back-to-back frames every 11 cycles, with pins changing ----
    for (int f = 0; f < 10; f++) begin
      tick(1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0);
      run_slots(1, LAST - 1, dirs_a, outs_a);
      pin_val = 24'($urandom);
      run_slots(LAST, LAST, dirs_a, outs_a);
    end
    tick(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    chk("final_pin_out", {8'd0, pin_out}, 32'h335A96);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
